kd_tree_query_ctrl: RTL and testbench

Sequencer for the register-based KD-tree internal node array. Loads the 127 internal node words through the tree's write port, then streams query patches into the tree with credit-based flow control. Collects the resulting leaf indices into a small output FIFO, so an upstream patch source and a downstream leaf consumer can both use valid/ready handshakes against a tree that cannot stall.

---
 rtl/kd_tree_query_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_kd_tree_query_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kd_tree_query_ctrl.sv
// KD-tree query sequencer: loads the internal node words, streams patches under credit flow control
// and buffers leaf results in a small FIFO. Define KD_CTRL_QUERY_ID_EN to add the leaf_qid output.
module kd_tree_query_ctrl #(
    parameter int INTERNAL_WIDTH  = 22,
    parameter int PATCH_WIDTH     = 55,
    parameter int ADDRESS_WIDTH   = 8,
    parameter int NUM_NODES       = 127,
    parameter int TREE_LATENCY    = 7,
    parameter int OUT_FIFO_DEPTH  = 8,
    parameter int QUERY_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [QUERY_CNT_WIDTH-1:0] num_queries,
    input  logic                       node_valid,
    output logic                       node_ready,
    input  logic [INTERNAL_WIDTH-1:0]  node_data,
    input  logic                       patch_valid,
    output logic                       patch_ready,
    input  logic [PATCH_WIDTH-1:0]     patch_data,
    output logic                       tree_fsm_enable,
    output logic                       tree_sender_enable,
    output logic [INTERNAL_WIDTH-1:0]  tree_sender_data,
    output logic [PATCH_WIDTH-1:0]     tree_patch_in,
    input  logic [ADDRESS_WIDTH-1:0]   tree_leaf_index,
    output logic                       leaf_valid,
    input  logic                       leaf_ready,
    output logic [ADDRESS_WIDTH-1:0]   leaf_index,
`ifdef KD_CTRL_QUERY_ID_EN
    output logic [QUERY_CNT_WIDTH-1:0] leaf_qid,
`endif
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LOAD_PAD,
        S_QUERY,
        S_DRAIN
    } state_t;

    localparam int NODE_CNT_W = $clog2(NUM_NODES + 1);
    localparam int PTR_W      = $clog2(OUT_FIFO_DEPTH);
    localparam int OCC_W      = PTR_W + 1;
`ifdef KD_CTRL_QUERY_ID_EN
    localparam int ENTRY_W    = QUERY_CNT_WIDTH + ADDRESS_WIDTH;
`else
    localparam int ENTRY_W    = ADDRESS_WIDTH;
`endif

    state_t                     r_state;
    state_t                     w_state_next;
    logic [QUERY_CNT_WIDTH-1:0] r_num_queries;
    logic [QUERY_CNT_WIDTH-1:0] r_issued;
    logic [NODE_CNT_W-1:0]      r_node_cnt;
    logic                       r_sender_en;
    logic [INTERNAL_WIDTH-1:0]  r_sender_data;
    logic [PATCH_WIDTH-1:0]     r_patch_in;
    logic                       r_issue_v;
    logic [TREE_LATENCY-1:0]    r_valid_sr;
    logic [OCC_W-1:0]           r_inflight;
    logic [OCC_W-1:0]           r_fifo_count;
    logic [PTR_W-1:0]           r_wr_ptr;
    logic [PTR_W-1:0]           r_rd_ptr;
    logic [ENTRY_W-1:0]         r_fifo_mem [OUT_FIFO_DEPTH];

    logic                       w_node_xfer;
    logic                       w_last_node;
    logic                       w_accept;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_fifo_empty;
    logic                       w_drained;
    logic [OCC_W-1:0]           w_occupancy;
    logic [ENTRY_W-1:0]         w_push_entry;
    logic [ENTRY_W-1:0]         w_head;

    assign w_fifo_empty = (r_fifo_count == '0);
    assign w_occupancy  = r_inflight + r_fifo_count;
    assign w_drained    = (r_inflight == '0) && w_fifo_empty;
    assign w_node_xfer  = node_valid && node_ready;
    assign w_last_node  = (r_node_cnt == NODE_CNT_W'(NUM_NODES - 1));
    assign w_accept     = patch_valid && patch_ready;
    assign w_push       = r_valid_sr[TREE_LATENCY-1];
    assign w_pop        = leaf_valid && leaf_ready;
    assign w_head       = r_fifo_mem[r_rd_ptr];

    assign tree_sender_enable = r_sender_en;
    assign tree_sender_data   = r_sender_data;
    assign tree_patch_in      = r_patch_in;
    // The pad write lands one cycle after LOAD_PAD, so the pending strobe keeps the window open.
    assign tree_fsm_enable    = (r_state == S_LOAD) || (r_state == S_LOAD_PAD) || r_sender_en;
    assign leaf_valid         = !w_fifo_empty;
    assign leaf_index         = w_fifo_empty ? '0 : w_head[ADDRESS_WIDTH-1:0];

    // NOTE: the reset is synchronous, so it lives inside the clocked branch and only acts on an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can leave it unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        node_ready   = 1'b0;
        patch_ready  = 1'b0;
        done         = 1'b0;
        busy         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                node_ready = 1'b1;
                if (w_node_xfer && w_last_node) w_state_next = S_LOAD_PAD;
            end
            S_LOAD_PAD: begin
                w_state_next = (r_num_queries == '0) ? S_DRAIN : S_QUERY;
            end
            S_QUERY: begin
                patch_ready = (r_issued < r_num_queries) &&
                              (w_occupancy < OCC_W'(OUT_FIFO_DEPTH));
                if (r_issued == r_num_queries) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                done = w_drained;
                if (w_drained) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_num_queries <= '0;
            r_issued      <= '0;
            r_node_cnt    <= '0;
            r_sender_en   <= 1'b0;
            r_sender_data <= '0;
            r_patch_in    <= '0;
            r_issue_v     <= 1'b0;
            r_valid_sr    <= '0;
            r_inflight    <= '0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_num_queries <= num_queries;
                r_issued      <= '0;
                r_node_cnt    <= '0;
            end
            if (w_node_xfer) r_node_cnt <= w_last_node ? '0 : r_node_cnt + NODE_CNT_W'(1);
            // The extra zero write in LOAD_PAD wraps the tree's 7-bit write address back to 0.
            r_sender_en   <= w_node_xfer || (r_state == S_LOAD_PAD);
            r_sender_data <= w_node_xfer ? node_data : '0;
            if (w_accept) begin
                r_patch_in <= patch_data;
                r_issued   <= r_issued + QUERY_CNT_WIDTH'(1);
            end
            r_issue_v  <= w_accept;
            r_valid_sr <= {r_valid_sr[TREE_LATENCY-2:0], r_issue_v};
            r_inflight <= r_inflight + OCC_W'(w_accept) - OCC_W'(w_push);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_fifo_count <= r_fifo_count + OCC_W'(w_push) - OCC_W'(w_pop);
        end
    end

    // NOTE: storage is deliberately not reset; the head is masked to 0 whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo_mem[r_wr_ptr] <= w_push_entry;
    end

`ifdef KD_CTRL_QUERY_ID_EN
    logic [QUERY_CNT_WIDTH-1:0] r_issue_qid;
    logic [QUERY_CNT_WIDTH-1:0] r_qid_sr [TREE_LATENCY];

    // Query ids ride a pipeline aligned with the in-flight valid bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_issue_qid <= '0;
            for (int i = 0; i < TREE_LATENCY; i++) r_qid_sr[i] <= '0;
        end else begin
            if (w_accept) r_issue_qid <= r_issued;
            r_qid_sr[0] <= r_issue_qid;
            for (int i = 1; i < TREE_LATENCY; i++) r_qid_sr[i] <= r_qid_sr[i-1];
        end
    end

    assign w_push_entry = {r_qid_sr[TREE_LATENCY-1], tree_leaf_index};
    assign leaf_qid     = w_fifo_empty ? '0 : w_head[ENTRY_W-1:ADDRESS_WIDTH];
`else
    assign w_push_entry = tree_leaf_index;
`endif

endmodule

// File: tb/tb_kd_tree_query_ctrl.sv
// Scoreboard bench for kd_tree_query_ctrl with a behavioural tree (write-address counter and
// a TREE_LATENCY pipeline returning patch[7:0]).
module tb_kd_tree_query_ctrl;

    localparam int IW = 22;
    localparam int PW = 55;
    localparam int AW = 8;
    localparam int QW = 16;
    localparam int TL = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [QW-1:0] num_queries = '0;
    logic          node_valid = 1'b0;
    logic          node_ready;
    logic [IW-1:0] node_data = '0;
    logic          patch_valid = 1'b0;
    logic          patch_ready;
    logic [PW-1:0] patch_data = '0;
    logic          tree_fsm_enable;
    logic          tree_sender_enable;
    logic [IW-1:0] tree_sender_data;
    logic [PW-1:0] tree_patch_in;
    logic [AW-1:0] tree_leaf_index;
    logic          leaf_valid;
    logic          leaf_ready = 1'b0;
    logic [AW-1:0] leaf_index;
    logic          busy;
    logic          done;
`ifdef KD_CTRL_QUERY_ID_EN
    logic [QW-1:0] leaf_qid;
`endif

    kd_tree_query_ctrl dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .num_queries        (num_queries),
        .node_valid         (node_valid),
        .node_ready         (node_ready),
        .node_data          (node_data),
        .patch_valid        (patch_valid),
        .patch_ready        (patch_ready),
        .patch_data         (patch_data),
        .tree_fsm_enable    (tree_fsm_enable),
        .tree_sender_enable (tree_sender_enable),
        .tree_sender_data   (tree_sender_data),
        .tree_patch_in      (tree_patch_in),
        .tree_leaf_index    (tree_leaf_index),
        .leaf_valid         (leaf_valid),
        .leaf_ready         (leaf_ready),
        .leaf_index         (leaf_index),
`ifdef KD_CTRL_QUERY_ID_EN
        .leaf_qid           (leaf_qid),
`endif
        .busy               (busy),
        .done               (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [QW-1:0] qid;
    } exp_t;

    typedef struct packed {
        logic [6:0]    addr;
        logic [IW-1:0] data;
    } wr_t;

    exp_t          exp_q[$];
    wr_t           wr_log[$];
    logic [7:0]    tx_leaf[$];
    exp_t          mon_e;
    int            n_compared = 0;
    int            n_mismatched = 0;
    int            cyc = 0;
    int            n_pops = 0;
    int            last_pop_cyc = -1;
    int            lat_accept_cyc = -1;
    int            lat_valid_cyc = -1;
    bit            lat_wait = 1'b0;
    bit            lat_measure = 1'b0;
    int            run_qid = 0;
    int            stray_writes = 0;
    logic [AW-1:0] tree_pipe [TL];
    logic [6:0]    tree_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Tree model: leaf index is the low byte of the patch presented TL cycles earlier.
    assign tree_leaf_index = tree_pipe[TL-1];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < TL; i++) tree_pipe[i] <= '0;
        end else begin
            tree_pipe[0] <= tree_patch_in[AW-1:0];
            for (int i = 1; i < TL; i++) tree_pipe[i] <= tree_pipe[i-1];
        end
    end

    // Tree write port model: 7-bit address, shares rst_n with the controller.
    always @(posedge clk) begin
        if (!rst_n) begin
            tree_addr <= '0;
        end else if (tree_sender_enable) begin
            if (!tree_fsm_enable) begin
                stray_writes <= stray_writes + 1;
            end else begin
                wr_log.push_back('{addr: tree_addr, data: tree_sender_data});
                tree_addr <= tree_addr + 7'd1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every leaf handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (lat_wait && leaf_valid) begin
                lat_valid_cyc = cyc;
                lat_wait      = 1'b0;
            end
            if (leaf_valid && leaf_ready) begin
                n_pops++;
                last_pop_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("leaf_unexpected", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("leaf_index", leaf_index, mon_e.idx);
`ifdef KD_CTRL_QUERY_ID_EN
                    check("leaf_qid", leaf_qid, mon_e.qid);
`endif
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input logic [QW-1:0] nq, input logic [IW-1:0] first_word);
        int sent;
        int guard;
        int strobe_err;
        bit xfer;
        sent = 0;
        guard = 0;
        strobe_err = 0;
        wr_log.delete();
        run_qid = 0;
        start = 1'b1;
        num_queries = nq;
        tick();
        start = 1'b0;
        while (sent < 127 && guard < 400) begin
            node_valid = (guard != 60);
            node_data  = first_word + IW'(sent);
            @(negedge clk);
            xfer = node_ready && node_valid;
            tick();
            if (xfer) begin
                if (!(tree_sender_enable && tree_sender_data == first_word + IW'(sent))) strobe_err++;
                sent++;
            end
            guard++;
        end
        node_valid = 1'b0;
        node_data  = '0;
        check("load_words_accepted", sent, 127);
        check("load_strobe_next_cycle", strobe_err, 0);
    endtask

    task automatic check_load(input logic [IW-1:0] first_word);
        check("wr_count", wr_log.size(), 128);
        if (wr_log.size() == 128) begin
            check("wr_first_addr", wr_log[0].addr, 0);
            check("wr_first_data", wr_log[0].data, first_word);
            check("wr_word127_data", wr_log[126].data, first_word + IW'(126));
            check("wr_pad_addr", wr_log[127].addr, 127);
            check("wr_pad_data", wr_log[127].data, 0);
        end
        check("stray_writes", stray_writes, 0);
    endtask

    task automatic send_patches(input int budget, output int n_acc);
        int used;
        bit acc;
        used = 0;
        n_acc = 0;
        while (tx_leaf.size() > 0 && used < budget) begin
            patch_valid = 1'b1;
            patch_data  = {47'h1234_5678_9ABC ^ 47'(run_qid), tx_leaf[0]};
            @(negedge clk);
            acc = patch_ready;
            if (acc && lat_measure) begin
                lat_accept_cyc = cyc;
                lat_wait       = 1'b1;
                lat_measure    = 1'b0;
            end
            tick();
            if (acc) begin
                exp_q.push_back('{idx: tx_leaf[0], qid: QW'(run_qid)});
                run_qid++;
                void'(tx_leaf.pop_front());
                n_acc++;
            end
            used++;
        end
        patch_valid = 1'b0;
        patch_data  = '1;
    endtask

    task automatic wait_done(input int budget);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        while (!got && n < budget) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                check("done_after_last_pop", cyc - last_pop_cyc, 1);
            end
            n++;
        end
        check("done_seen", got, 1);
        tick();
        check("idle_after_done", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_acc;
        int pops0;

        // Reset state
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_node_ready", node_ready, 0);
        check("rst_patch_ready", patch_ready, 0);
        check("rst_leaf_valid", leaf_valid, 0);
        check("rst_leaf_index", leaf_index, 0);
        check("rst_sender_en", tree_sender_enable, 0);
        check("rst_fsm_en", tree_fsm_enable, 0);
        check("rst_patch_in", tree_patch_in, 0);
        rst_n = 1'b1;
        tick();

        // Run 1: load words 1..127 with zero queries
        run_load(16'd0, 22'd1);
        @(negedge clk);
        check("t1_node_ready_after_127", node_ready, 0);
        check("t1_done_not_in_pad", done, 0);
        tick();
        @(negedge clk);
        check("t1_done_after_pad", done, 1);
        tick();
        check("t1_idle", busy, 0);
        tick();
        check_load(22'd1);

        // Run 2: four queries, leaf_ready high
        leaf_ready = 1'b1;
        run_load(16'd4, 22'h100);
        tx_leaf = '{8'h11, 8'h22, 8'h33, 8'h44};
        lat_measure = 1'b1;
        pops0 = n_pops;
        send_patches(40, n_acc);
        check("t2_accepted", n_acc, 4);
        wait_done(60);
        check("t2_first_latency", lat_valid_cyc - lat_accept_cyc, 9);
        check("t2_pops", n_pops - pops0, 4);
        check("t2_scoreboard_empty", exp_q.size(), 0);
        check("t2_patch_in_held", tree_patch_in, {47'h1234_5678_9ABC ^ 47'd3, 8'h44});
        check_load(22'h100);

        // Run 3: back-to-back, 20 queries with the consumer stalled
        leaf_ready = 1'b0;
        run_load(16'd20, 22'h200);
        for (int i = 0; i < 20; i++) tx_leaf.push_back(8'hA0 + 8'(i));
        pops0 = n_pops;
        send_patches(30, n_acc);
        check("t3_credit_limit", n_acc, 8);
        @(negedge clk);
        check("t3_ready_low_when_full", patch_ready, 0);
        check("t3_leaf_valid_stalled", leaf_valid, 1);
        tick();
        num_queries = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t3_start_ignored_busy", busy, 1);
        leaf_ready = 1'b1;
        send_patches(200, n_acc);
        check("t3_remaining_accepted", n_acc, 12);
        wait_done(100);
        check("t3_pops", n_pops - pops0, 20);
        check("t3_scoreboard_empty", exp_q.size(), 0);
        check_load(22'h200);

        // Run 4: reset in the middle of QUERY, then a clean run
        leaf_ready = 1'b0;
        run_load(16'd6, 22'h300);
        tx_leaf = '{8'h01, 8'h02, 8'h03};
        send_patches(10, n_acc);
        repeat (12) tick();
        @(negedge clk);
        check("t4_fifo_has_data", leaf_valid, 1);
        tick();
        rst_n = 1'b0;
        tick();
        check("t4_rst_busy", busy, 0);
        check("t4_rst_leaf_valid", leaf_valid, 0);
        check("t4_rst_leaf_index", leaf_index, 0);
        check("t4_rst_patch_in", tree_patch_in, 0);
        check("t4_rst_patch_ready", patch_ready, 0);
        check("t4_rst_sender_en", tree_sender_enable, 0);
        check("t4_rst_fsm_en", tree_fsm_enable, 0);
        check("t4_rst_done", done, 0);
        exp_q.delete();
        tx_leaf.delete();
        rst_n = 1'b1;
        leaf_ready = 1'b1;
        tick();
        run_load(16'd4, 22'h001);
        tx_leaf = '{8'h5A, 8'hC3, 8'h0F, 8'hF0};
        pops0 = n_pops;
        send_patches(40, n_acc);
        check("t4_accepted", n_acc, 4);
        wait_done(60);
        check("t4_pops", n_pops - pops0, 4);
        check("t4_scoreboard_empty", exp_q.size(), 0);
        check_load(22'h001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
